// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   loader_state_e  : loader FSM states (IDLE, LOAD, RUN)
//   INSTR_W         : fetched instruction width in bits
//   BYTES_PER_INSTR : bytes assembled per fetch
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } loader_state_e;

  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;

endpackage

// File: rtl/imem_byte_store.sv
// Byte-organised program store: one synchronous write port and a
// combinational big-endian 4-byte read starting at rd_addr.
//   clk     : system clock
//   wr_en   : write wr_data to mem[wr_addr] on the rising edge
//   wr_addr : byte write address
//   wr_data : byte to write
//   rd_addr : base byte address of the read
//   rd_word : {mem[a], mem[a+1], mem[a+2], mem[a+3]}, indices modulo MEM_BYTES
module imem_byte_store
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [7:0]         wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_word
);

  logic [7:0] mem [MEM_BYTES];

  // No reset: program contents survive a reset and are simply stale.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Address arithmetic is ADDR_W bits wide, so a+i wraps modulo MEM_BYTES.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES_PER_INSTR; i++) begin
      rd_word[INSTR_W-1-8*i -: 8] = mem[rd_addr + ADDR_W'(i)];
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader and fetch responder.
// A host streams bytes in (load_*) which are written sequentially from
// address 0; once loaded, the fetch stage reads 32-bit big-endian words
// (fetch_*) with a fixed one-cycle latency.
//   clk, rst                 : clock, synchronous active-high reset
//   load_start               : pulse, begin (or restart) a load at address 0
//   load_valid/byte/last     : byte stream from the host
//   load_ready               : byte accepted this cycle (high in LOAD)
//   load_done                : pulse the cycle after the final byte
//   load_count               : bytes written by current/last load
//   fetch_req, fetch_addr    : fetch request and byte address
//   fetch_ready              : request accepted this cycle
//   fetch_valid/instr/err    : registered response; err flags misalignment
//
// state | meaning
// IDLE  | no valid program; waiting for load_start
// LOAD  | accepting bytes into the store
// RUN   | program present; serving fetches
module imem_program_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_done,
  output logic [ADDR_W:0]    load_count,
  input  logic               fetch_req,
  input  logic [31:0]        fetch_addr,
  output logic               fetch_ready,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               fetch_err
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(MEM_BYTES);

  loader_state_e state;

  logic               wr_en;
  logic               load_finish;
  logic [ADDR_W:0]    count_next;
  logic               fetch_accept;
  logic               misaligned;
  logic [INSTR_W-1:0] rd_word;
  logic               unused_addr_hi;

  // A restart in the same cycle as a byte takes priority; the byte is dropped.
  assign wr_en       = load_valid && load_ready && !load_start;
  assign count_next  = load_count + (ADDR_W+1)'(1);
  assign load_finish = wr_en && (load_last || (count_next == FULL_COUNT));

  assign fetch_ready  = (state == ST_RUN) && !load_start;
  assign fetch_accept = fetch_req && fetch_ready;
  assign misaligned   = |fetch_addr[1:0];

  // Upper PC bits alias onto the store.
  assign unused_addr_hi = &{1'b0, fetch_addr[31:ADDR_W]};

  imem_byte_store #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_count[ADDR_W-1:0]),
    .wr_data (load_byte),
    .rd_addr (fetch_addr[ADDR_W-1:0]),
    .rd_word (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_err   <= 1'b0;
    end else begin
      load_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
            load_count <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            load_count <= '0;
          end else if (wr_en) begin
            load_count <= count_next;
            if (load_finish) begin
              state      <= ST_RUN;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (load_start) begin
            state      <= ST_LOAD;
            load_ready <= 1'b1;
            load_count <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b0;
        end
      endcase

      // Response register: instr/err hold between responses.
      fetch_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_err   <= misaligned;
        fetch_instr <= misaligned ? '0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench: the driver pushes each expected fetch response into a
// scoreboard queue when it issues the request; an independent monitor pops
// and compares whenever fetch_valid is seen.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [8:0]  load_count;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  imem_program_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_count  (load_count),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] prog_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_ref;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (fetch_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_fetch_valid: got instr 0x%08h err %0b, expected no response (cycle %0d)",
                 fetch_instr, fetch_err, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("fetch_instr", 64'(fetch_instr), 64'(mon_e.instr));
        check("fetch_err", 64'(fetch_err), 64'(mon_e.err));
        check("fetch_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  task automatic load_bytes(input bit use_last);
    for (int i = 0; i < prog_q.size(); i++) begin
      load_valid = 1'b1;
      load_byte  = prog_q[i];
      load_last  = use_last && (i == prog_q.size() - 1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic post_load(input int exp_count);
    @(negedge clk);
    check("load_done_pulse", 64'(load_done), 64'd1);
    check("load_count", 64'(load_count), 64'(exp_count));
    check("run_fetch_ready", 64'(fetch_ready), 64'd1);
    check("run_load_ready", 64'(load_ready), 64'd0);
    @(negedge clk);
    check("load_done_single", 64'(done_cnt), 64'(done_ref + 1));
    check("load_done_low", 64'(load_done), 64'd0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                       input logic exp_err, input bit exp_accept);
    @(posedge clk); #1;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    @(negedge clk);
    check("fetch_ready", 64'(fetch_ready), 64'(exp_accept));
    if (exp_accept) sb_q.push_back('{instr: exp_instr, err: exp_err, due: cyc + 1});
  endtask

  task automatic fetch_idle();
    @(posedge clk); #1 fetch_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'h00;
    load_last = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_count", 64'(load_count), 64'd0);
    check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    check("rst_fetch_instr", 64'(fetch_instr), 64'd0);
    check("rst_fetch_err", 64'(fetch_err), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full 8-byte load with load_last
    prog_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    done_ref = done_cnt;
    start_load();
    @(negedge clk);
    check("load_ready_in_load", 64'(load_ready), 64'd1);
    @(posedge clk); #1;
    load_bytes(1'b1);
    post_load(8);

    // Back-to-back, misaligned and aliased fetches
    fetch(32'h0000_0000, 32'h2008_0005, 1'b0, 1'b1);
    fetch(32'h0000_0004, 32'h8C09_0004, 1'b0, 1'b1);
    fetch(32'h0000_0002, 32'h0000_0000, 1'b1, 1'b1);
    fetch(32'h0000_0104, 32'h8C09_0004, 1'b0, 1'b1);
    fetch_idle();
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_fetch_valid", 64'(fetch_valid), 64'd0);
    check("fetch_instr_hold", 64'(fetch_instr), 64'h8C09_0004);

    // Full-store load, no load_last
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back(8'(i));
    done_ref = done_cnt;
    start_load();
    load_bytes(1'b0);
    post_load(256);
    fetch(32'h0000_00FC, 32'hFCFD_FEFF, 1'b0, 1'b1);
    fetch(32'h0000_0000, 32'h0001_0203, 1'b0, 1'b1);
    fetch(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b1);
    fetch_idle();

    // Reload while running, with a fetch request colliding with load_start
    @(posedge clk); #1;
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(negedge clk);
    check("reload_fetch_ready", 64'(fetch_ready), 64'd0);
    @(posedge clk); #1;
    load_start = 1'b0;
    fetch_req  = 1'b0;
    @(negedge clk);
    check("reload_load_count", 64'(load_count), 64'd0);
    check("reload_load_ready", 64'(load_ready), 64'd1);
    prog_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    done_ref = done_cnt;
    load_bytes(1'b1);
    post_load(4);
    fetch(32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    fetch(32'h0000_0004, 32'h0405_0607, 1'b0, 1'b1);
    fetch(32'hFFFF_FF00, 32'hDEAD_BEEF, 1'b0, 1'b1);
    fetch_idle();

    // Reset in the middle of a load
    prog_q = '{8'h11, 8'h22, 8'h33};
    done_ref = done_cnt;
    start_load();
    load_bytes(1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_load_ready", 64'(load_ready), 64'd0);
    check("midrst_fetch_ready", 64'(fetch_ready), 64'd0);
    check("midrst_load_count", 64'(load_count), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    fetch(32'h0000_0000, 32'h0, 1'b0, 1'b0);
    fetch_idle();
    repeat (3) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt), 64'(done_ref));
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Instruction-memory responder for the fetch stage, and the writer side of the same byte-organised instruction memory.
- Accepts a byte stream from the test/boot host and writes it sequentially into a byte-addressed program store starting at address 0.
- Once loaded, serves 32-bit big-endian instruction fetches to the fetch stage through a req/valid handshake.
- Sits between the host load interface and the PC/fetch logic.

Parameters:
- MEM_BYTES, 256, program store size in bytes; power of two, at least 4.
- ADDR_W, 8, log2(MEM_BYTES); number of byte-address bits used.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- load_start  in  1  one-cycle pulse that begins a program load.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte.
- load_last  in  1  qualifies load_valid: this byte is the final program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  number of bytes written by the current or last load.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  byte address (PC).
- fetch_ready  out  1  fetch_req is accepted this cycle.
- fetch_valid  out  1  response valid; one-cycle pulse.
- fetch_instr  out  32  fetched instruction.
- fetch_err  out  1  qualifies fetch_valid: misaligned request.

Behaviour:
- State machine: IDLE -> LOAD -> RUN.
  - IDLE: no program present. Enter LOAD on load_start.
  - LOAD: leave for RUN on an accepted byte with load_last=1, or on an accepted byte that makes load_count equal MEM_BYTES.
  - RUN: re-enter LOAD on load_start.
- Reset: state=IDLE, load_ready=0, load_done=0, load_count=0, fetch_ready=0, fetch_valid=0, fetch_instr=0, fetch_err=0. Memory contents are not cleared.
- Reset mid-load: return to IDLE. Bytes already written remain in memory but are not a valid program.
- Load start: on entering LOAD, the write pointer and load_count clear to 0.
- Byte writes: load_ready=1 throughout LOAD. A byte is accepted when load_valid && load_ready. It is written to mem[write pointer], then the pointer and load_count increment.
- Load completion: load_done pulses in the cycle after the final byte is accepted, coincident with state=RUN.
- Bytes presented outside LOAD are ignored. load_start during LOAD restarts the load at address 0.
- fetch_ready = (state==RUN) && !load_start. Requests made while fetch_ready=0 are dropped; the requester holds and retries.
- Fetch latency: exactly 1 cycle. A request accepted in cycle N produces fetch_valid=1 in cycle N+1. Back-to-back requests give one response per cycle.
- Fetch addressing: a = fetch_addr[ADDR_W-1:0]; fetch_addr[31:ADDR_W] is ignored (aliasing).
- Big-endian assembly: fetch_instr = {mem[a], mem[a+1], mem[a+2], mem[a+3]}, all four byte addresses distinct.
- Byte index wrap: each byte index is taken modulo MEM_BYTES.
- Misaligned fetch: if fetch_addr[1:0] != 0, the response has fetch_err=1 and fetch_instr=0.
- Output hold: fetch_instr holds its last value when fetch_valid=0.
- Simultaneous events: a request accepted in the same cycle that load_start asserts cannot occur, because fetch_ready=0. A response already registered is still delivered in the following cycle.
- Uninitialised memory: reads of bytes beyond load_count return the stale memory contents. This is not an error.

Decomposition:
- Shared package imem_pkg holds:
  - loader state enum (IDLE, LOAD, RUN);
  - INSTR_W=32;
  - BYTES_PER_INSTR=4.
- One sub-module, imem_byte_store: a 1-write-port byte memory with a 4-byte combinational read at base address a with wrap.
- The FSM, counters and the fetch response register stay in the top.

Test Plan:
- Full load: rst, load_start, then bytes 0x20,0x08,0x00,0x05,0x8C,0x09,0x00,0x04 with load_last on the 8th -> load_done pulses once, load_count=8, state RUN.
- Fetches after load: fetch 0x0 then 0x4 in consecutive cycles -> 0x20080005 and 0x8C090004 on consecutive cycles, each with fetch_valid=1, fetch_err=0, and 1-cycle latency.
- Misaligned and aliased fetches:
  - fetch 0x2 -> fetch_valid=1, fetch_err=1, fetch_instr=0;
  - fetch 0x00000104 -> same as 0x4 (aliasing).
- Wrap-around load: load 256 bytes valued 0x00..0xFF with no load_last -> load_done after byte 256, load_count=256.
  - Fetch 0xFC -> 0xFCFDFEFF.
- Reset mid-load: rst after 3 accepted bytes -> IDLE, fetch_ready=0, load_count=0.
  - fetch_req is ignored, with no fetch_valid.
- Reload while running: load_start during RUN with fetch_req high -> fetch_ready=0 that cycle, load_count=0.
  - A new 4-byte load of 0xDEADBEEF, then fetch 0x0 -> 0xDEADBEEF.
